// File: rtl/medevac_fsm.sv
// Alarm/actuation controller for the medevac monitoring unit.
// Six fault flags are reduced to warning/critical classes and tracked with an acknowledge in a Moore FSM.
module medevac_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       ST,
  input  logic       HS,
  input  logic       OC,
  input  logic       CS,
  input  logic       IM,
  input  logic       WS,
  input  logic       ACK,
  output logic       HP,
  output logic       HV,
  output logic       OM,
  output logic       FS,
  output logic       AT,
  output logic       AL,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    WARNING  = 2'b01,
    CRITICAL = 2'b10,
    ACKED    = 2'b11
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   warn;
  logic   crit;
  logic [5:0] outs_next;

  assign warn = ST | HS;
  assign crit = OC | CS | IM | WS;

  always_comb begin
    state_next = NORMAL;
    case (state_reg)
      NORMAL, WARNING: begin
        if (crit)      state_next = CRITICAL;
        else if (warn) state_next = WARNING;
        else           state_next = NORMAL;
      end
      CRITICAL: begin
        if (crit && ACK) state_next = ACKED;
        else if (crit)   state_next = CRITICAL;
        else if (warn)   state_next = WARNING;
        else             state_next = NORMAL;
      end
      ACKED: begin
        // The acknowledge stays latched for as long as any critical flag is up.
        if (crit)      state_next = ACKED;
        else if (warn) state_next = WARNING;
        else           state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // Output order: {HP, HV, OM, FS, AT, AL}
  always_comb begin
    outs_next = 6'b000000;
    case (state_next)
      NORMAL:   outs_next = 6'b000000;
      WARNING:  outs_next = 6'b001110;
      CRITICAL: outs_next = 6'b111101;
      ACKED:    outs_next = 6'b111110;
      default:  outs_next = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= NORMAL;
      {HP, HV, OM, FS, AT, AL} <= 6'b000000;
    end else begin
      state_reg <= state_next;
      {HP, HV, OM, FS, AT, AL} <= outs_next;
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_medevac_fsm.sv
// Directed bench for medevac_fsm; each check compares {state, HP,HV,OM,FS,AT,AL}.
module tb_medevac_fsm;

  logic clk = 1'b0;
  logic rst;
  logic ST, HS, OC, CS, IM, WS, ACK;
  logic HP, HV, OM, FS, AT, AL;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] E_NORM = 8'b00_000000;
  localparam logic [7:0] E_WARN = 8'b01_001110;
  localparam logic [7:0] E_CRIT = 8'b10_111101;
  localparam logic [7:0] E_ACKD = 8'b11_111110;

  medevac_fsm dut (
    .clk(clk), .rst(rst),
    .ST(ST), .HS(HS), .OC(OC), .CS(CS), .IM(IM), .WS(WS), .ACK(ACK),
    .HP(HP), .HV(HV), .OM(OM), .FS(FS), .AT(AT), .AL(AL),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end else begin
      $display("ok   %s = %b", tag, got);
    end
  endtask

  function automatic logic [7:0] obs();
    return {state, HP, HV, OM, FS, AT, AL};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input logic [5:0] f, input logic a);
    {ST, HS, OC, CS, IM, WS} = f;
    ACK = a;
  endtask

  initial begin
    rst = 1'b0;
    flags(6'b101010, 1'b1);
    #1;
    check("reset_async", obs(), E_NORM);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), obs(), E_NORM);
      flags(6'($urandom), 1'($urandom));
    end

    flags(6'b000000, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d", i), obs(), E_NORM);
    end

    // Warning path
    ST = 1'b1; step(); check("warn_st", obs(), E_WARN);
    ST = 1'b0; step(); check("warn_clear", obs(), E_NORM);
    HS = 1'b1; step(); check("warn_hs", obs(), E_WARN);
    HS = 1'b0; step(); check("warn_hs_clear", obs(), E_NORM);

    // Critical then acknowledge
    OC = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("crit_hold%0d", i), obs(), E_CRIT);
    end
    ACK = 1'b1; step(); check("ack", obs(), E_ACKD);

    // Ack latching across flag swap with ACK dropped
    flags(6'b000110, 1'b0); step(); check("ack_latch", obs(), E_ACKD);
    step(); check("ack_latch2", obs(), E_ACKD);
    flags(6'b000000, 1'b0); step(); check("ack_clear", obs(), E_NORM);

    // Priority of C over W
    flags(6'b100001, 1'b0); step(); check("prio_direct_crit", obs(), E_CRIT);
    WS = 1'b0; step(); check("crit_to_warn", obs(), E_WARN);
    ST = 1'b0; step(); check("warn_to_norm", obs(), E_NORM);

    // Critical flag swap while C stays high
    OC = 1'b1; step(); check("swap_enter", obs(), E_CRIT);
    OC = 1'b0; IM = 1'b1; step(); check("swap_stay", obs(), E_CRIT);

    // C falls while ACK rises: !C rule wins
    flags(6'b010000, 1'b1); step(); check("cfall_ackrise", obs(), E_WARN);
    flags(6'b000000, 1'b1); step(); check("ack_ignored_norm", obs(), E_NORM);

    // ACK held while entering critical: CRITICAL for one cycle first
    OC = 1'b1; step(); check("ackheld_crit", obs(), E_CRIT);
    step(); check("ackheld_acked", obs(), E_ACKD);

    // Async reset pulse between edges while ACKED
    #2 rst = 1'b0;
    #1 check("async_mid_acked", obs(), E_NORM);
    #1 rst = 1'b1;
    step(); check("post_reset_crit", obs(), E_CRIT);
    step(); check("post_reset_acked", obs(), E_ACKD);
    flags(6'b000000, 1'b0); step(); check("final_norm", obs(), E_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/medevac_fsm.md
# medevac_fsm

Alarm/actuation controller for the medical-evacuation monitoring unit. It condenses six sensor fault flags into a warning condition and a critical condition. It tracks an operator acknowledge in a four-state Moore machine and drives six actuator/indicator outputs plus a state code for display and logging. It sits between the sensor-conditioning logic (clean, already-synchronous flags) and the alarm/actuator drivers.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately; release synchronous to clk is the integrator's duty)
- ST  in  1  warning-class sensor flag
- HS  in  1  warning-class sensor flag
- OC  in  1  critical-class sensor flag
- CS  in  1  critical-class sensor flag
- IM  in  1  critical-class sensor flag
- WS  in  1  critical-class sensor flag
- ACK  in  1  operator acknowledge, level-sensitive
- HP  out  1  high-priority flag
- HV  out  1  high-volume ventilation enable
- OM  out  1  oxygen mode enable
- FS  out  1  fan/stabilizer enable
- AT  out  1  attention indicator (non-audible)
- AL  out  1  audible alarm
- state  out  2  current state code

## Operation
- Derived conditions, combinational from inputs:
  - W = ST | HS
  - C = OC | CS | IM | WS
- States and encodings: NORMAL=2'b00, WARNING=2'b01, CRITICAL=2'b10, ACKED=2'b11. `state` outputs the register directly.
- Next-state rules, evaluated in priority order per state:
  - NORMAL: C -> CRITICAL; else W -> WARNING; else NORMAL.
  - WARNING: C -> CRITICAL; else W -> WARNING; else NORMAL.
  - CRITICAL: C&ACK -> ACKED; C&!ACK -> CRITICAL; !C&W -> WARNING; else NORMAL.
  - ACKED: C -> ACKED, whatever ACK does (an acknowledge latches until C clears); !C&W -> WARNING; else NORMAL.
- ACK is ignored in NORMAL and WARNING. ACK held high while entering CRITICAL gives CRITICAL for one cycle, then ACKED; CRITICAL is never skipped.
- A change from one critical flag to another while C stays 1 does not change state.
- Moore outputs, decoded from the state register (no input paths):
  - NORMAL: all six outputs 0.
  - WARNING: OM=1, FS=1, AT=1; all others 0.
  - CRITICAL: HP=1, HV=1, OM=1, FS=1, AL=1; AT=0.
  - ACKED: HP=1, HV=1, OM=1, FS=1, AT=1; AL=0 (alarm silenced, attention kept).
- Implement the six outputs as registers loaded from the next-state decode, so they change on the same edge as `state`.
- Illegal encodings cannot occur (all four codes are used).

## Timing
- Reset: asserting rst low immediately forces state=NORMAL and HP=HV=OM=FS=AT=AL=0, independent of clk.
- Reset applied mid-operation (for example in ACKED) drops the acknowledge. After release, the FSM re-evaluates from NORMAL on the next edge.
- Latency: a change in inputs sampled at rising edge k appears on `state` and all outputs after edge k (one-cycle latency). There is no combinational input-to-output path.
- Two-step paths take two edges. ACK=1 together with C rising from NORMAL: NORMAL -> CRITICAL at edge k, then CRITICAL -> ACKED at edge k+1.
- Simultaneous W and C: C has priority in every state.
- Simultaneous C falling and ACK rising in CRITICAL: the !C rule wins (go to WARNING or NORMAL).

## Test plan
- Reset: hold rst=0 for 4 cycles with arbitrary inputs -> state=00, all outputs 0. Release rst with all flags 0 -> stays 00 for 10 cycles.
- Warning path: from NORMAL set ST=1 -> one edge later state=01, OM=FS=AT=1, HP=HV=AL=0. Clear ST -> state=00 one edge later.
- Critical/ack path: set OC=1 with ACK=0 -> state=10, AL=1, AT=0, held for 10 cycles. Then ACK=1 -> state=11, AL=0, AT=1.
- Ack latching: in ACKED, swap OC=0 for CS=IM=1 and drop ACK -> state stays 11, outputs unchanged. Clear all flags -> state=00, all outputs 0.
- Priority: from NORMAL set ST=1 and WS=1 together -> state=10 directly. In CRITICAL, clear WS while ST=1 -> state=01.
- Async reset mid-ACKED: pulse rst low between edges -> outputs clear immediately without a clock edge. After release with OC=1 and ACK=1 -> state goes 10, then 11.
